uart_rx: RTL and testbench

Serial UART receiver; the receive-side counterpart of the team's UART transmitter, sharing its frame format (1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line). It synchronizes the asynchronous `rx` pin, validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit. It presents each received byte with a one-cycle valid strobe to the host logic.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and the receiver state enum.
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), optional even parity, 1 stop bit.
// UART_RX_PARITY_EN enables the parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  , output logic                    parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(UART_DATA_BITS - 1);

  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic rx_s, valid_n, ferr_n, bit_done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n, perr_n;
`endif

  assign bit_done = (cnt == BIT_LAST);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      data      <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          cnt_n     = '0;
          par_bad_n = rx_s ^ (^shreg);
          state_n   = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          cnt_n  = '0;
          data_n = shreg;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          if (rx_s) begin
            valid_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int EXP_LAT = 2 + H + (FRAME_BITS - 1) * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] vdata [0:15];
  int         vcyc  [0:15];
  logic [7:0] fdata = 8'h00;
  logic       both_seen = 1'b0;
  logic       last_perr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && frame_err) both_seen = 1'b1;
    if (rx_valid) begin
      if (valid_cnt < 16) begin
        vdata[valid_cnt] = data;
        vcyc[valid_cnt]  = cyc;
      end
      valid_cnt++;
    end
    if (frame_err) begin
      fdata = data;
      ferr_cnt++;
    end
`ifdef UART_RX_PARITY_EN
    if (rx_valid || frame_err) last_perr = parity_err;
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(C);
  endtask

  task automatic test_basic();
    int t0, v0, f0, lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hAD, 1'b1, t0);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected %0d", valid_cnt - v0, 1); end
    checks++;
    if (ferr_cnt !== f0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
    checks++;
    if (vdata[v0] !== 8'hAD) begin errors++; $display("FAIL basic_data: got %h expected ad", vdata[v0]); end
    lat = vcyc[v0] - t0;
    checks++;
    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1)
      begin errors++; $display("FAIL basic_latency: got %0d expected %0d +/-1", lat, EXP_LAT); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    checks++;
    if (vdata[v0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", vdata[v0]); end
    checks++;
    if (vdata[v0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", vdata[v0+1]); end
    checks++;
    if (vcyc[v0+1] - vcyc[v0] !== FRAME_BITS * C)
      begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", vcyc[v0+1] - vcyc[v0], FRAME_BITS * C); end
  endtask

  task automatic test_glitch();
    int v0, f0, busy_cyc;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cyc = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_cyc < 1 || busy_cyc > 8) begin errors++; $display("FAIL glitch_busy: got %0d cycles expected 1..8", busy_cyc); end
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== f0)
      begin errors++; $display("FAIL glitch_strobe: got %0d strobes expected 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
  endtask

  task automatic test_break();
    int t0, v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, t0);
    rx = 1'b0;
    tick(40);
    checks++;
    if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (fdata !== 8'h55) begin errors++; $display("FAIL break_data: got %h expected 55", fdata); end
    checks++;
    if (valid_cnt !== v0) begin errors++; $display("FAIL break_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL break_hold_busy: got %b expected 1", busy); end
    rx = 1'b1;
    tick(4);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL break_release_busy: got %b expected 0", busy); end
    tick(C);
    send_frame(8'h3C, 1'b1, t0);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL break_next_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (vdata[v0] !== 8'h3C) begin errors++; $display("FAIL break_next_data: got %h expected 3c", vdata[v0]); end
  endtask

  task automatic test_mid_reset();
    int t0, v0, f0;
    logic [7:0] b;
    b = 8'hA5;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    tick(H);
    reset = 1'b1;
    rx = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0)
      begin errors++; $display("FAIL midrst_strobes: got %b%b expected 00", rx_valid, frame_err); end
    tick(12 * C);
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== f0)
      begin errors++; $display("FAIL midrst_no_strobe: got %0d strobes expected 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
    send_frame(8'hA5, 1'b1, t0);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (vdata[v0] !== 8'hA5) begin errors++; $display("FAIL midrst_next_data: got %h expected a5", vdata[v0]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask

  task automatic test_parity();
    int v0;
    v0 = valid_cnt;
    send_frame_par(8'h07, 1'b0);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (last_perr !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", last_perr); end
    send_frame_par(8'h07, 1'b1);
    tick(4);
    checks++;
    if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL par_good_count: got %0d expected 2", valid_cnt - v0); end
    checks++;
    if (last_perr !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", last_perr); end
    checks++;
    if (vdata[v0+1] !== 8'h07) begin errors++; $display("FAIL par_data: got %h expected 07", vdata[v0+1]); end
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    tick(C);
    test_glitch();
    test_break();
    tick(C);
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    tick(C);
    test_parity();
`endif
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe_exclusive: got %b expected 0", both_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
